// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one single-port program/data memory between
// instruction fetch (port 0) and load/store (port 1), with a timeout watchdog.
module memory_arbiter #(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [11:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_done,
    output logic        p0_err,
    output logic [7:0]  p0_rdata,

    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [11:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [7:0]  p1_rdata,

    output logic        mem_enable,
    output logic        mem_write,
    output logic        mem_strobe,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Counter value on the last WAIT cycle before the watchdog fires.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  req_vec;
    logic [1:0]  write_vec;
    logic [11:0] addr_vec  [2];
    logic [7:0]  wdata_vec [2];
    logic [1:0]  done_vec;
    logic [1:0]  err_vec;
    logic [7:0]  rdata_vec [2];

    assign req_vec      = {p1_req, p0_req};
    assign write_vec    = {p1_write, p0_write};
    assign addr_vec[0]  = p0_addr;
    assign addr_vec[1]  = p1_addr;
    assign wdata_vec[0] = p0_wdata;
    assign wdata_vec[1] = p1_wdata;

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic        write_reg, write_next;
    logic [11:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic [7:0]  count_reg, count_next;
    logic        err_reg, err_next;

    logic        winner;
    logic        capture_en;
    logic [7:0]  capture_data;

    // On a tie, round-robin hands the grant to the port that did not go last.
    always_comb begin
        if (req_vec == 2'b11) begin
            winner = FIXED_PRIORITY ? 1'b0 : ~last_grant_reg;
        end else begin
            winner = req_vec[1];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg      <= S_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            count_reg      <= count_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        count_next      = count_reg;
        err_next        = err_reg;
        capture_en      = 1'b0;
        capture_data    = '0;

        case (state_reg)
            S_IDLE: begin
                if (|req_vec) begin
                    grant_next = winner;
                    write_next = write_vec[winner];
                    addr_next  = addr_vec[winner];
                    wdata_next = wdata_vec[winner];
                    err_next   = 1'b0;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                count_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    capture_en   = 1'b1;
                    capture_data = write_reg ? 8'h00 : mem_rdata;
                    state_next   = S_DONE;
                end else if (count_reg == COUNT_LAST) begin
                    capture_en = 1'b1;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            S_DONE: begin
                last_grant_next = grant_reg;
                state_next      = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Per-port result registers: read data persists until that port's next completion.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [7:0] rdata_reg;

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    rdata_reg <= '0;
                end else if (capture_en && (grant_reg == 1'(gi))) begin
                    rdata_reg <= capture_data;
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign done_vec[gi]  = (state_reg == S_DONE) && (grant_reg == 1'(gi));
            assign err_vec[gi]   = done_vec[gi] && err_reg;
        end
    endgenerate

    assign p0_done  = done_vec[0];
    assign p0_err   = err_vec[0];
    assign p0_rdata = rdata_vec[0];
    assign p1_done  = done_vec[1];
    assign p1_err   = err_vec[1];
    assign p1_rdata = rdata_vec[1];

    assign mem_enable = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign mem_strobe = (state_reg == S_ISSUE);
    assign mem_write  = mem_enable && write_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations plus a
// transaction-level model checked against the round-robin instance every cycle.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int TO = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        p0_req = 1'b0, p0_write = 1'b0;
    logic [11:0] p0_addr = '0;
    logic [7:0]  p0_wdata = '0;
    logic        p1_req = 1'b0, p1_write = 1'b0;
    logic [11:0] p1_addr = '0;
    logic [7:0]  p1_wdata = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready;

    logic        p0_done, p0_err, p1_done, p1_err;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        mem_enable, mem_write, mem_strobe;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        fp_p0_done, fp_p0_err, fp_p1_done, fp_p1_err;
    logic [7:0]  fp_p0_rdata, fp_p1_rdata;
    logic        fp_mem_enable, fp_mem_write, fp_mem_strobe;
    logic [11:0] fp_mem_addr;
    logic [7:0]  fp_mem_wdata;

    int checks = 0;
    int failures = 0;

    bit auto_ready = 1'b0;
    bit manual_ready = 1'b0;

    memory_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_strobe(mem_strobe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    memory_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT(TO)) dut_fp (
        .aclk(aclk), .areset(areset),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(fp_p0_done), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(fp_p1_done), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
        .mem_enable(fp_mem_enable), .mem_write(fp_mem_write), .mem_strobe(fp_mem_strobe),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Memory responder: either answers on the first WAIT cycle or follows manual_ready.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            mem_ready = auto_ready ? (mem_enable && !mem_strobe) : manual_ready;
        end
    end

    // Transaction-level model of the round-robin instance.
    bit          m_busy = 1'b0, m_done = 1'b0, m_port = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    bit          m_last = 1'b1;
    logic [11:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rdata [2] = '{8'h00, 8'h00};
    int          m_age = 0;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
            m_port     <= 1'b0;
            m_wr       <= 1'b0;
            m_err      <= 1'b0;
            m_last     <= 1'b1;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
            m_age      <= 0;
        end else if (!m_busy) begin
            if (p0_req || p1_req) begin
                m_busy  <= 1'b1;
                m_age   <= 0;
                m_err   <= 1'b0;
                m_port  <= pick(p0_req, p1_req, m_last);
                m_wr    <= pick(p0_req, p1_req, m_last) ? p1_write : p0_write;
                m_addr  <= pick(p0_req, p1_req, m_last) ? p1_addr : p0_addr;
                m_wdata <= pick(p0_req, p1_req, m_last) ? p1_wdata : p0_wdata;
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_last <= m_port;
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (mem_ready) begin
            m_done          <= 1'b1;
            m_rdata[m_port] <= m_wr ? 8'h00 : mem_rdata;
        end else if (m_age == TO) begin
            m_done          <= 1'b1;
            m_err           <= 1'b1;
            m_rdata[m_port] <= 8'h00;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge aclk) begin
        bit en;
        bit st;
        en = m_busy && !m_done;
        st = en && (m_age == 0);
        check("cyc_ctrl", {mem_enable, mem_strobe, mem_write & mem_enable}, {en, st, en & m_wr});
        if (en) check("cyc_bus", {mem_addr, mem_wdata}, {m_addr, m_wdata});
        check("cyc_p0", {p0_done, p0_done & p0_err, p0_rdata},
              {m_done && !m_port, m_done && !m_port && m_err, m_rdata[0]});
        check("cyc_p1", {p1_done, p1_done & p1_err, p1_rdata},
              {m_done && m_port, m_done && m_port && m_err, m_rdata[1]});
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit rr_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n;

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_outputs", {mem_enable, mem_strobe, mem_write, mem_addr, mem_wdata,
              p0_done, p0_err, p1_done, p1_err, p0_rdata}, 32'h0);

        // Single read from port 0
        tick();
        areset = 1'b0;
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 12'h123; mem_rdata = 8'hA5; auto_ready = 1'b1;
        tick(); @(negedge aclk);
        check("rd_issue", {mem_strobe, mem_enable, mem_addr}, {1'b1, 1'b1, 12'h123});
        tick();
        tick(); p0_req = 1'b0; @(negedge aclk);
        check("rd_done", {p0_done, p0_err, p0_rdata, mem_enable}, {1'b1, 1'b0, 8'hA5, 1'b0});

        // Write from port 1
        tick();
        p1_req = 1'b1; p1_write = 1'b1; p1_addr = 12'hFFF; p1_wdata = 8'h3C; mem_rdata = 8'h77;
        tick(); @(negedge aclk);
        check("wr_issue", {mem_enable, mem_strobe, mem_write, mem_wdata}, {1'b1, 1'b1, 1'b1, 8'h3C});
        tick(); @(negedge aclk);
        check("wr_wait", {mem_enable, mem_strobe, mem_write, mem_wdata, mem_addr},
              {1'b1, 1'b0, 1'b1, 8'h3C, 12'hFFF});
        tick(); p1_req = 1'b0; @(negedge aclk);
        check("wr_done", {p1_done, p1_err, p1_rdata, p0_done}, {1'b1, 1'b0, 8'h00, 1'b0});

        // Both ports requesting continuously, from a fresh reset
        tick(); areset = 1'b1;
        tick();
        tick();
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 12'h010;
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 12'h020; mem_rdata = 8'h42;
        areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge aclk);
                n++;
            end while (!(p0_done || p1_done) && n < 12);
            check("rr_spacing", 32'(n), 32'd4);
            check("rr_grant", {p0_done, p1_done}, {!rr_exp[k], rr_exp[k]});
            check("fp_grant", {fp_p0_done, fp_p1_done}, {1'b1, 1'b0});
        end
        p0_req = 1'b0; p1_req = 1'b0;

        // Watchdog: memory never answers
        tick();
        auto_ready = 1'b0; manual_ready = 1'b0;
        p0_req = 1'b1; p0_addr = 12'h055; p0_write = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            @(negedge aclk);
        end while (!p0_done && n < 20);
        check("to_cycles", 32'(n), 32'd6);
        check("to_done", {p0_done, p0_err, p0_rdata}, {1'b1, 1'b1, 8'h00});
        p0_req = 1'b0;

        // Reset asserted while waiting on the memory
        tick();
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 12'h2AB; mem_rdata = 8'h99;
        tick();
        tick(); @(negedge aclk);
        check("rst_pre_wait", {mem_enable, mem_strobe, mem_addr}, {1'b1, 1'b0, 12'h2AB});
        tick();
        #1 areset = 1'b1;
        #1;
        check("rst_async", {mem_enable, mem_strobe, mem_write, mem_addr, p1_done, p0_done}, 32'h0);
        tick();
        areset = 1'b0; auto_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            @(negedge aclk);
        end while (!p1_done && n < 10);
        check("rst_regrant_cycles", 32'(n), 32'd3);
        check("rst_regrant", {p1_done, p1_err, p1_rdata}, {1'b1, 1'b0, 8'h99});
        p1_req = 1'b0;

        // Stray ready in IDLE and ISSUE, and request inputs moving after the grant
        tick();
        auto_ready = 1'b0; manual_ready = 1'b1;
        tick();
        tick(); @(negedge aclk);
        check("stray_idle", {p0_done, p1_done, mem_enable}, 32'h0);
        tick();
        p0_req = 1'b1; p0_write = 1'b0; p0_addr = 12'h0AA; mem_rdata = 8'h5E;
        tick();
        p0_addr = 12'h0BB; p0_write = 1'b1;
        @(negedge aclk);
        check("stray_issue", {mem_strobe, mem_write, mem_addr}, {1'b1, 1'b0, 12'h0AA});
        tick(); @(negedge aclk);
        check("stray_wait", {mem_enable, p0_done, mem_addr}, {1'b1, 1'b0, 12'h0AA});
        tick(); p0_req = 1'b0; manual_ready = 1'b0; @(negedge aclk);
        check("stray_done", {p0_done, p0_err, p0_rdata}, {1'b1, 1'b0, 8'h5E});

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequences and shares the shader's single-port program/data memory between two requesters: port 0 (instruction fetch, driven by the branch/control unit) and port 1 (load/store).
- Grants one requester at a time, drives the memory's enable/write/strobe/address/data inputs, and waits for the memory's ready.
- Returns read data and a one-cycle completion pulse to the granted requester.
- A watchdog aborts any transaction the memory fails to complete.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.
- TIMEOUT, 255, WAIT cycles allowed before abort (1..255, 8-bit counter).

Ports:
- aclk  input  1  clock, all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- p0_req  input  1  port 0 request, level, held until p0_done
- p0_write  input  1  port 0 write (1) / read (0)
- p0_addr  input  12  port 0 address
- p0_wdata  input  8  port 0 write data
- p0_done  output  1  port 0 completion pulse
- p0_err  output  1  port 0 timeout flag, valid with p0_done
- p0_rdata  output  8  port 0 read data, valid with p0_done
- p1_req, p1_write, p1_addr, p1_wdata, p1_done, p1_err, p1_rdata  (same as port 0)
- mem_enable  output  1  memory enable, high ISSUE..WAIT
- mem_write  output  1  memory write select
- mem_strobe  output  1  one-cycle transaction start
- mem_addr  output  12  memory address (program counter)
- mem_wdata  output  8  memory write data
- mem_rdata  input  8  memory read data
- mem_ready  input  1  memory completion

Behaviour:
- Reset (async assert, sync deassert by design): state IDLE; all outputs 0; last_grant = 1, so port 0 wins the first tie; timeout counter 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, select the winner, latch write/addr/wdata and the grant index, go to ISSUE. Otherwise stay.
- Winner selection, one requester: that requester.
- Winner selection, both requesting: if FIXED_PRIORITY=1, port 0; else the port not equal to last_grant.
- ISSUE (1 cycle): mem_enable=1, mem_strobe=1, mem_write/addr/wdata from latched values; counter cleared; go to WAIT. mem_ready is ignored in this cycle.
- WAIT: mem_enable=1, mem_strobe=0, address/data held stable.
  - On mem_ready=1: latch mem_rdata (reads only; writes return 0), go to DONE.
  - Else increment counter. When counter reaches TIMEOUT with no ready: set err, rdata=0, go to DONE.
- DONE (1 cycle): mem_enable=0; granted pX_done=1, pX_err as recorded, pX_rdata valid; last_grant updated; go to IDLE.
- pX_rdata holds its value until that port's next DONE.
- Latency: req sampled in IDLE at cycle 0, ISSUE at cycle 1, WAIT at cycle 2. Ready in cycle 2 gives done in cycle 3, the minimum. A back-to-back grant is possible from cycle 4.
- Requests are not re-sampled until IDLE. A requester dropping req mid-transaction does not abort it; done is still pulsed.
- A requester holding req through its own DONE is treated as a new request in the following IDLE, subject to arbitration.
- Requester inputs changing after the latch in IDLE have no effect on the current transaction.
- mem_ready outside WAIT is ignored.
- Reset mid-transaction: immediate return to the reset state. No done pulse; the outstanding request is dropped.
- Never more than one pX_done high in any cycle; done is never asserted outside DONE.

Test Plan:
- Single read: p0_req, addr=0x123, mem_rdata=0xA5, ready in first WAIT cycle -> mem_strobe high cycle 1 with mem_addr=0x123, p0_done and p0_rdata=0xA5 in cycle 3, mem_enable low in cycle 3.
- Write: p1_req, write=1, addr=0xFFF, wdata=0x3C -> mem_write=1, mem_wdata=0x3C during ISSUE/WAIT, p1_done with p1_rdata=0x00, p1_err=0.
- Round-robin, FIXED_PRIORITY=0: both reqs held continuously -> grants alternate 0,1,0,1 starting with port 0. With FIXED_PRIORITY=1 -> port 0 only.
- Timeout, TIMEOUT=4: mem_ready never asserted -> after 4 WAIT cycles the requester gets done=1, err=1, rdata=0x00, then returns to IDLE.
- Reset mid-WAIT: assert areset asynchronously -> all outputs 0 immediately, no done. After release, a pending request is regranted from IDLE.
- Stray mem_ready in IDLE/ISSUE plus a requester changing addr after grant -> no completion from the stray ready, and mem_addr keeps the latched value.
